// File: rtl/rx_link_pkg.sv
// rx_link_pkg
//   Shared definitions for the per-channel Aurora RX link controller:
//   frame FSM state encoding and default header-detect constants.
package rx_link_pkg;

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    HUNT      = 2'd1,
    PASS      = 2'd2,
    DROP      = 2'd3
  } link_state_t;

  localparam logic [31:0] HDR_MASK_DEF  = 32'hFFFF_0000;
  localparam logic [31:0] HDR_VALUE_DEF = 32'hA5A5_0000;

endpackage

// File: rtl/rx_link_watchdog.sv
// rx_link_watchdog
//   Counts consecutive link-down cycles and, after WDOG_CYCLES-1 of them,
//   emits a lane reset pulse of exactly RST_PULSE cycles. The counter restarts
//   at each pulse, so a link that stays down is re-requested periodically.
//   A link coming up mid-pulse does not shorten the pulse.
// Ports:
//   clk          channel user clock
//   rst_n        asynchronous active-low reset
//   link_active  channel_up from the Aurora core
//   link_rst_o   lane reset request pulse
module rx_link_watchdog #(
  parameter int unsigned WDOG_CYCLES = 65536,
  parameter int unsigned RST_PULSE   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic link_active,
  output logic link_rst_o
);

  localparam int unsigned CW = $clog2(WDOG_CYCLES);
  localparam int unsigned PW = $clog2(RST_PULSE + 1);
  // The counter holds the number of down cycles already seen, so the cycle
  // that completes WDOG_CYCLES-1 of them is the one where it reads WDOG_CYCLES-2.
  localparam logic [CW-1:0] FIRE_AT = CW'(WDOG_CYCLES - 2);
  localparam logic [PW-1:0] PULSE_LEN = PW'(RST_PULSE);

  logic [CW-1:0] down_cnt;
  logic [PW-1:0] pulse_left;
  logic          fire;

  assign fire = !link_active && (down_cnt == FIRE_AT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_cnt   <= '0;
      pulse_left <= '0;
    end else begin
      if (link_active || fire) begin
        down_cnt <= '0;
      end else begin
        down_cnt <= down_cnt + 1'b1;
      end

      if (fire) begin
        pulse_left <= PULSE_LEN;
      end else if (pulse_left != '0) begin
        pulse_left <= pulse_left - 1'b1;
      end
    end
  end

  assign link_rst_o = (pulse_left != '0);

endmodule

// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl
//   Per-channel receive controller between an Aurora local-link RX port and
//   its capture FIFO. STREAM mode (FRAMED=0) forwards every valid word;
//   FRAMED mode aligns to header words and bounds frame length. FIFO overflow
//   is accounted in a saturating drop counter and a sticky error flag.
// Ports:
//   clk, rst_n     channel user clock, async active-low reset
//   rx_d           received word
//   rx_src_rdy_n   active-low word valid
//   link_active    channel_up from the Aurora core
//   fifo_data_o    FIFO write data (registered)
//   fifo_wren_o    FIFO write enable (registered, one cycle after accept)
//   fifo_full_i    FIFO full
//   link_rst_o     lane reset request pulse from the watchdog
//   drop_cnt_o     words discarded, saturating
//   frame_cnt_o    frames completely written, wrapping
//   err_o          sticky overflow/overlength flag
module rx_link_ctrl
  import rx_link_pkg::*;
#(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       FRAMED      = 0,
  parameter logic [WIDTH-1:0]  HDR_MASK    = WIDTH'(HDR_MASK_DEF),
  parameter logic [WIDTH-1:0]  HDR_VALUE   = WIDTH'(HDR_VALUE_DEF),
  parameter int unsigned       MAX_WORDS   = 256,
  parameter int unsigned       WDOG_CYCLES = 65536,
  parameter int unsigned       RST_PULSE   = 8,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rx_d,
  input  logic             rx_src_rdy_n,
  input  logic             link_active,
  output logic [WIDTH-1:0] fifo_data_o,
  output logic             fifo_wren_o,
  input  logic             fifo_full_i,
  output logic             link_rst_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             err_o
);

  localparam int unsigned   LW      = $clog2(MAX_WORDS + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_WORDS);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);

  link_state_t   state, state_nx;
  logic [LW-1:0] len, len_nx;
  logic          valid, hdr;
  logic          wr_nx, drop_inc, frame_inc, err_set;

  assign valid = !rx_src_rdy_n && link_active;
  assign hdr   = ((rx_d & HDR_MASK) == HDR_VALUE);

  always_comb begin
    state_nx  = state;
    len_nx    = len;
    wr_nx     = 1'b0;
    drop_inc  = 1'b0;
    frame_inc = 1'b0;
    err_set   = 1'b0;

    if (!link_active) begin
      state_nx = LINK_DOWN;
    end else begin
      unique case (state)
        LINK_DOWN: begin
          state_nx = (FRAMED != 0) ? HUNT : PASS;
          len_nx   = '0;
        end

        HUNT: begin
          // A header found while the FIFO is full starts a frame that cannot
          // be stored; treat it like an overflow inside PASS.
          if (valid && hdr) begin
            if (fifo_full_i) begin
              drop_inc = 1'b1;
              err_set  = 1'b1;
              state_nx = DROP;
            end else begin
              wr_nx    = 1'b1;
              len_nx   = LEN_ONE;
              state_nx = PASS;
            end
          end
        end

        PASS: begin
          if (valid) begin
            if (FRAMED == 0) begin
              if (fifo_full_i) begin
                drop_inc = 1'b1;
                err_set  = 1'b1;
              end else begin
                wr_nx = 1'b1;
              end
            end else if (hdr) begin
              frame_inc = 1'b1;
              if (fifo_full_i) begin
                drop_inc = 1'b1;
                err_set  = 1'b1;
                state_nx = DROP;
              end else begin
                wr_nx  = 1'b1;
                len_nx = LEN_ONE;
              end
            end else if (len == LEN_MAX) begin
              drop_inc = 1'b1;
              err_set  = 1'b1;
              state_nx = HUNT;
            end else if (fifo_full_i) begin
              drop_inc = 1'b1;
              err_set  = 1'b1;
              state_nx = DROP;
            end else begin
              wr_nx  = 1'b1;
              len_nx = len + 1'b1;
            end
          end
        end

        DROP: begin
          if (valid) begin
            if (hdr && !fifo_full_i) begin
              wr_nx    = 1'b1;
              len_nx   = LEN_ONE;
              state_nx = PASS;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end

        default: state_nx = LINK_DOWN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LINK_DOWN;
      len         <= '0;
      fifo_wren_o <= 1'b0;
      fifo_data_o <= '0;
      drop_cnt_o  <= '0;
      frame_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_nx;
      len         <= len_nx;
      fifo_wren_o <= wr_nx;
      if (wr_nx) begin
        fifo_data_o <= rx_d;
      end
      if (drop_inc && (drop_cnt_o != '1)) begin
        drop_cnt_o <= drop_cnt_o + 1'b1;
      end
      if (frame_inc) begin
        frame_cnt_o <= frame_cnt_o + 1'b1;
      end
      if (err_set) begin
        err_o <= 1'b1;
      end
    end
  end

  rx_link_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES),
    .RST_PULSE   (RST_PULSE)
  ) u_wdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .link_active (link_active),
    .link_rst_o  (link_rst_o)
  );

endmodule

// File: tb/tb_rx_link_ctrl.sv
// tb_rx_link_ctrl
//   Drives three controller instances (stream; framed; framed with short
//   frames, narrow counters and a short reset pulse) from one shared random
//   and directed stimulus stream and compares each against a reference model.
module tb_rx_link_ctrl;

  localparam int NDUT = 3;
  localparam int WDOG = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rx_d = '0;
  logic        rx_src_rdy_n = 1'b1;
  logic        link_active = 1'b0;
  logic        fifo_full_i = 1'b0;

  logic [31:0] data0, data1, data2;
  logic        wren0, wren1, wren2;
  logic        lrst0, lrst1, lrst2;
  logic [15:0] drop0, drop1, frame0, frame1;
  logic [3:0]  drop2, frame2;
  logic        err0, err1, err2;

  logic [31:0] o_data  [NDUT];
  logic [31:0] o_drop  [NDUT];
  logic [31:0] o_frame [NDUT];
  logic        o_wren  [NDUT];
  logic        o_lrst  [NDUT];
  logic        o_err   [NDUT];

  always #5 clk = ~clk;

  rx_link_ctrl #(.FRAMED(0), .WDOG_CYCLES(WDOG), .RST_PULSE(8)) u_stream (
    .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_src_rdy_n(rx_src_rdy_n),
    .link_active(link_active), .fifo_data_o(data0), .fifo_wren_o(wren0),
    .fifo_full_i(fifo_full_i), .link_rst_o(lrst0), .drop_cnt_o(drop0),
    .frame_cnt_o(frame0), .err_o(err0));

  rx_link_ctrl #(.FRAMED(1), .WDOG_CYCLES(WDOG), .RST_PULSE(8)) u_framed (
    .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_src_rdy_n(rx_src_rdy_n),
    .link_active(link_active), .fifo_data_o(data1), .fifo_wren_o(wren1),
    .fifo_full_i(fifo_full_i), .link_rst_o(lrst1), .drop_cnt_o(drop1),
    .frame_cnt_o(frame1), .err_o(err1));

  rx_link_ctrl #(.FRAMED(1), .MAX_WORDS(4), .WDOG_CYCLES(WDOG), .RST_PULSE(3), .CNT_W(4)) u_short (
    .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_src_rdy_n(rx_src_rdy_n),
    .link_active(link_active), .fifo_data_o(data2), .fifo_wren_o(wren2),
    .fifo_full_i(fifo_full_i), .link_rst_o(lrst2), .drop_cnt_o(drop2),
    .frame_cnt_o(frame2), .err_o(err2));

  assign o_data[0] = data0;  assign o_data[1] = data1;  assign o_data[2] = data2;
  assign o_wren[0] = wren0;  assign o_wren[1] = wren1;  assign o_wren[2] = wren2;
  assign o_lrst[0] = lrst0;  assign o_lrst[1] = lrst1;  assign o_lrst[2] = lrst2;
  assign o_err[0]  = err0;   assign o_err[1]  = err1;   assign o_err[2]  = err2;
  assign o_drop[0] = {16'b0, drop0};
  assign o_drop[1] = {16'b0, drop1};
  assign o_drop[2] = {28'b0, drop2};
  assign o_frame[0] = {16'b0, frame0};
  assign o_frame[1] = {16'b0, frame1};
  assign o_frame[2] = {28'b0, frame2};

  // Per-instance configuration as seen by the model.
  int framed_p [NDUT] = '{0, 1, 1};
  int maxw_p   [NDUT] = '{256, 256, 4};
  int dmax_p   [NDUT] = '{65535, 65535, 15};
  int fmod_p   [NDUT] = '{65536, 65536, 16};
  int pulse_p  [NDUT] = '{8, 8, 3};

  // Model view: whether the link has been seen up, whether we are aligned to a
  // frame, whether we are discarding until the next header, and how many words
  // the current frame holds. Watchdog: length of the current down run and the
  // number of reset-pulse cycles still owed.
  typedef struct {
    bit          up;
    bit          synced;
    bit          dropping;
    int          len;
    bit          wr;
    logic [31:0] data;
    int          drops;
    int          frames;
    bit          err;
    int          down_run;
    int          pulse_left;
  } mdl_t;

  mdl_t m [NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  bit nrst_drive = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_clear();
    mdl_t z;
    z = '{default: 0};
    z.data = '0;
    return z;
  endfunction

  function automatic bit is_hdr(input logic [31:0] d);
    return d[31:16] == 16'hA5A5;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t mi, input int k, input logic [31:0] d,
                                    input bit v, input bit l, input bit f);
    mdl_t r;
    bit   h;
    r    = mi;
    r.wr = 1'b0;
    h    = is_hdr(d);

    // Watchdog: fires on the (WDOG-1)-th consecutive down cycle.
    if (l) begin
      r.down_run = 0;
      if (r.pulse_left > 0) r.pulse_left--;
    end else begin
      r.down_run++;
      if (r.down_run == WDOG - 1) begin
        r.down_run   = 0;
        r.pulse_left = pulse_p[k];
      end else if (r.pulse_left > 0) begin
        r.pulse_left--;
      end
    end

    if (!l) begin
      r.up = 1'b0;
    end else if (!r.up) begin
      r.up       = 1'b1;
      r.synced   = (framed_p[k] == 0);
      r.dropping = 1'b0;
      r.len      = 0;
    end else if (v) begin
      bit drop_it;
      drop_it = 1'b0;
      if (framed_p[k] == 0) begin
        if (f) begin drop_it = 1'b1; r.err = 1'b1; end
        else r.wr = 1'b1;
      end else if (!r.synced) begin
        if (h) begin
          r.synced = 1'b1;
          if (f) begin drop_it = 1'b1; r.err = 1'b1; r.dropping = 1'b1; end
          else begin r.wr = 1'b1; r.len = 1; end
        end
      end else if (r.dropping) begin
        if (h && !f) begin r.wr = 1'b1; r.len = 1; r.dropping = 1'b0; end
        else drop_it = 1'b1;
      end else if (h) begin
        r.frames = (r.frames + 1) % fmod_p[k];
        if (f) begin drop_it = 1'b1; r.err = 1'b1; r.dropping = 1'b1; end
        else begin r.wr = 1'b1; r.len = 1; end
      end else if (r.len >= maxw_p[k]) begin
        drop_it = 1'b1; r.err = 1'b1; r.synced = 1'b0;
      end else if (f) begin
        drop_it = 1'b1; r.err = 1'b1; r.dropping = 1'b1;
      end else begin
        r.wr = 1'b1; r.len++;
      end
      if (r.wr) r.data = d;
      if (drop_it && r.drops < dmax_p[k]) r.drops++;
    end
    return r;
  endfunction

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("u%0d_wren", k), {31'b0, o_wren[k]}, {31'b0, m[k].wr});
      if (m[k].wr) check_eq($sformatf("u%0d_data", k), o_data[k], m[k].data);
      check_eq($sformatf("u%0d_drop_cnt", k), o_drop[k], m[k].drops);
      check_eq($sformatf("u%0d_frame_cnt", k), o_frame[k], m[k].frames);
      check_eq($sformatf("u%0d_err", k), {31'b0, o_err[k]}, {31'b0, m[k].err});
      check_eq($sformatf("u%0d_link_rst", k), {31'b0, o_lrst[k]}, {31'b0, m[k].pulse_left > 0});
    end
  endtask

  task automatic cycle(input logic [31:0] d, input bit v, input bit l, input bit f);
    @(negedge clk);
    check_all();
    rx_d         = d;
    rx_src_rdy_n = !v;
    link_active  = l;
    fifo_full_i  = f;
    rst_n        = nrst_drive;
    for (int k = 0; k < NDUT; k++)
      m[k] = rst_n ? mdl_step(m[k], k, d, v, l, f) : mdl_clear();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    nrst_drive = 1'b0;
    rst_n      = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) m[k] = mdl_clear();
    check_all();
  endtask

  initial begin
    int down_left;
    logic [31:0] d;
    bit v, l, f;

    for (int k = 0; k < NDUT; k++) m[k] = mdl_clear();

    repeat (3) cycle(32'h0, 1'b0, 1'b0, 1'b0);
    nrst_drive = 1'b1;
    repeat (2) cycle(32'h0, 1'b0, 1'b1, 1'b0);

    // Stream burst 0..9, then 10..19 with three words hitting a full FIFO.
    for (int i = 0; i < 10; i++) cycle(32'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 10; i < 20; i++) cycle(32'(i), 1'b1, 1'b1, (i >= 13 && i <= 15));

    // Framed alignment: junk, header, 4 data, header.
    cycle(32'h1234_5678, 1'b1, 1'b1, 1'b0);
    cycle(32'hA5A5_0001, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(32'h100 + 32'(i), 1'b1, 1'b1, 1'b0);
    cycle(32'hA5A5_0002, 1'b1, 1'b1, 1'b0);

    // Overflow on word 2, three more data, then a fresh header.
    cycle(32'h200, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) cycle(32'h200 + 32'(i), 1'b1, 1'b1, 1'b0);
    cycle(32'hA5A5_0003, 1'b1, 1'b1, 1'b0);
    cycle(32'h0, 1'b0, 1'b1, 1'b0);

    // Overlength on the short-frame instance, then re-alignment.
    cycle(32'hA5A5_0004, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(32'h300 + 32'(i), 1'b1, 1'b1, 1'b0);
    cycle(32'h3FF, 1'b1, 1'b1, 1'b0);
    cycle(32'hA5A5_0005, 1'b1, 1'b1, 1'b0);
    cycle(32'h400, 1'b1, 1'b1, 1'b0);

    // Watchdog: long outage, short outage, outage ending mid-pulse.
    repeat (40) cycle(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3)  cycle(32'h0, 1'b0, 1'b1, 1'b0);
    repeat (10) cycle(32'h0, 1'b1, 1'b0, 1'b0);
    repeat (20) cycle(32'h0, 1'b0, 1'b1, 1'b0);
    repeat (17) cycle(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (12) cycle(32'h0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a frame.
    cycle(32'hA5A5_0006, 1'b1, 1'b1, 1'b0);
    cycle(32'h500, 1'b1, 1'b1, 1'b0);
    cycle(32'h501, 1'b1, 1'b1, 1'b0);
    async_reset();
    repeat (2) cycle(32'h502, 1'b1, 1'b1, 1'b0);
    nrst_drive = 1'b1;
    repeat (2) cycle(32'h0, 1'b0, 1'b1, 1'b0);

    // Random traffic with occasional outages.
    down_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (down_left == 0 && $urandom_range(0, 199) == 0) down_left = $urandom_range(1, 40);
      l = (down_left == 0);
      if (down_left > 0) down_left--;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 99) < 15) ? {16'hA5A5, 16'($urandom)} : 32'($urandom);
      cycle(d, v, l, f);
    end

    cycle(32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
